// File: rtl/user_pkg.sv
// user_pkg: user-domain address map plus SHA-256 controller offsets and FSM states
package user_pkg;
    localparam logic [31:0] UserSha256AddrOffset = 32'h2000_1000;
    localparam logic [31:0] UserSha256AddrRange  = 32'h0000_1000;
    localparam int unsigned UserSha256Idx = 1;
    localparam int unsigned NumUserDomainSubordinates = 1;

    typedef enum int unsigned {
        UserError  = 0,
        UserSha256 = 1
    } user_demux_outputs_e;

    localparam logic [11:0] ShaCtrlOff   = 12'h000;
    localparam logic [11:0] ShaStatusOff = 12'h004;
    localparam logic [11:0] ShaCyclesOff = 12'h008;
    localparam logic [11:0] ShaMsgOff    = 12'h040;
    localparam logic [11:0] ShaDigOff    = 12'h080;

    typedef enum logic [1:0] {
        sha_idle  = 2'd0,
        sha_issue = 2'd1,
        sha_busy  = 2'd2
    } sha_ctrl_state_e;
endpackage

// File: rtl/user_sha256_ctrl.sv
// user_sha256_ctrl: OBI subordinate that buffers a 512-bit block, drives an external SHA-256 core and captures its digest
// Ports: clk_i/rst_i (sync, active high); obi_* subordinate bus (gnt = req, response one cycle later);
//        core_init_o/core_next_o/core_block_o to the core, core_ready_i/core_digest_valid_i/core_digest_i back;
//        irq_o = DONE & IRQ_EN.
module user_sha256_ctrl
    import user_pkg::*;
#(
    parameter int unsigned IdWidth       = 1,
    parameter int unsigned TimeoutCycles = 1024,
    parameter int unsigned CntWidth      = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               obi_req_i,
    input  logic               obi_we_i,
    input  logic [3:0]         obi_be_i,
    input  logic [31:0]        obi_addr_i,
    input  logic [31:0]        obi_wdata_i,
    input  logic [IdWidth-1:0] obi_aid_i,
    output logic               obi_gnt_o,
    output logic               obi_rvalid_o,
    output logic [31:0]        obi_rdata_o,
    output logic [IdWidth-1:0] obi_rid_o,
    output logic               obi_err_o,
    output logic               core_init_o,
    output logic               core_next_o,
    output logic [511:0]       core_block_o,
    input  logic               core_ready_i,
    input  logic               core_digest_valid_i,
    input  logic [255:0]       core_digest_i,
    output logic               irq_o
);
    sha_ctrl_state_e state_q, state_d;
    logic irq_en_q, first_q, done_q, timeout_q;
    logic [CntWidth-1:0] cycles_q;
    logic [31:0] msg_q [16];
    logic [31:0] dig_q [8];
    logic rvalid_q, err_q;
    logic [31:0] rdata_q, rd;
    logic [IdWidth-1:0] rid_q;
    logic [11:0] off;
    logic is_ctrl, is_status, is_cycles, is_msg, is_dig, busy, acc_err, wr_ok;
    logic start_ok, done_set, timeout_set;
    logic unused_addr;

    assign off         = obi_addr_i[11:0];
    assign unused_addr = ^obi_addr_i[31:12];
    assign is_ctrl     = off == ShaCtrlOff;
    assign is_status   = off == ShaStatusOff;
    assign is_cycles   = off == ShaCyclesOff;
    assign is_msg      = off[11:6] == ShaMsgOff[11:6] && off[1:0] == 2'b00;
    assign is_dig      = off[11:5] == ShaDigOff[11:5] && off[1:0] == 2'b00;
    assign busy        = state_q != sha_idle;

    // START is only legal from IDLE with the core idle; otherwise the whole CTRL write is rejected
    assign acc_err = !(is_ctrl || is_status || is_cycles || is_msg || is_dig) || obi_be_i != 4'hF ||
                     (obi_we_i && (is_cycles || is_dig || (is_msg && busy) ||
                                   (is_ctrl && obi_wdata_i[0] && (busy || !core_ready_i))));
    assign wr_ok    = obi_req_i && obi_we_i && !acc_err;
    assign start_ok = wr_ok && is_ctrl && obi_wdata_i[0];

    assign done_set    = state_q == sha_busy && core_digest_valid_i && core_ready_i;
    assign timeout_set = state_q == sha_busy && !done_set && cycles_q >= CntWidth'(TimeoutCycles - 1);

    assign rd = is_ctrl   ? {29'd0, irq_en_q, 2'd0} :
                is_status ? {29'd0, timeout_q, done_q, busy} :
                is_cycles ? 32'(cycles_q) :
                is_msg    ? msg_q[off[5:2]] :
                is_dig    ? dig_q[off[4:2]] : '0;

    always_comb begin
        state_d     = state_q;
        core_init_o = 1'b0;
        core_next_o = 1'b0;
        state_d     = state_q == sha_idle  ? (start_ok ? sha_issue : sha_idle) :
                      state_q == sha_issue ? sha_busy :
                      (done_set || timeout_set) ? sha_idle : sha_busy;
        core_init_o = state_q == sha_issue && first_q;
        core_next_o = state_q == sha_issue && !first_q;
    end

    always_comb begin
        core_block_o = '0;
        for (int i = 0; i < 16; i++) core_block_o[511-32*i -: 32] = msg_q[i];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= sha_idle;
            irq_en_q  <= 1'b0;
            first_q   <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            cycles_q  <= '0;
            rvalid_q  <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
            rid_q     <= '0;
            for (int i = 0; i < 16; i++) msg_q[i] <= '0;
            for (int i = 0; i < 8; i++) dig_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            rvalid_q <= obi_req_i;
            rid_q    <= obi_aid_i;
            err_q    <= obi_req_i && acc_err;
            rdata_q  <= (obi_req_i && !obi_we_i && !acc_err) ? rd : '0;
            if (wr_ok && is_ctrl) begin
                irq_en_q <= obi_wdata_i[2];
                first_q  <= obi_wdata_i[1];
            end
            if (wr_ok && is_msg) msg_q[off[5:2]] <= obi_wdata_i;
            // ISSUE restarts the count at 1 because the ISSUE cycle itself is counted
            cycles_q <= state_q == sha_issue ? CntWidth'(1) :
                        state_q == sha_busy  ? cycles_q + CntWidth'(cycles_q != '1) : cycles_q;
            done_q    <= done_set || (done_q && !(state_q == sha_issue || (wr_ok && is_status && obi_wdata_i[1])));
            timeout_q <= timeout_set || (timeout_q && !(state_q == sha_issue || (wr_ok && is_status && obi_wdata_i[2])));
            if (done_set) for (int i = 0; i < 8; i++) dig_q[i] <= core_digest_i[255-32*i -: 32];
        end
    end

    assign obi_gnt_o    = obi_req_i;
    assign obi_rvalid_o = rvalid_q;
    assign obi_rdata_o  = rdata_q;
    assign obi_rid_o    = rid_q;
    assign obi_err_o    = err_q;
    assign irq_o        = done_q && irq_en_q;
endmodule
